// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   MULT_N       default operand width
//   cnt_width()  iteration counter width for a given operand width
//   state enum and the matching state constants used by the FSM
// Optional feature macro (see shift_add_mult.sv): MULT_EARLY_EXIT_EN
package mult_pkg;

    localparam int MULT_N = 6;

    // A width-1 counter is kept for N<2 so the counter never collapses to 0 bits.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int MULT_CNT_W = cnt_width(MULT_N);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_LOAD = 2'd1,
        E_CALC = 2'd2,
        E_DONE = 2'd3
    } mult_state_e;

    localparam logic [1:0] ST_IDLE = E_IDLE;
    localparam logic [1:0] ST_LOAD = E_LOAD;
    localparam logic [1:0] ST_CALC = E_CALC;
    localparam logic [1:0] ST_DONE = E_DONE;

endpackage

// File: rtl/shift_add_dp.sv
// Shift-and-add datapath: accumulator, shifting multiplicand and multiplier.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset (clears all registers)
//   i_ld                    load acc<-R, mcand<-B, mplier<-Q
//   i_step                  one iteration: shift mcand left, mplier right
//   i_add                   with i_step, accumulate mcand into acc
//   i_q, i_b, i_r           operands (N bits each)
//   o_acc                   accumulator (2N bits)
//   o_mplier_lsb            current multiplier LSB
//   o_next_mplier_zero      multiplier will be zero after this shift
module shift_add_dp
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_ld,
    input  logic           i_step,
    input  logic           i_add,
    input  logic [N-1:0]   i_q,
    input  logic [N-1:0]   i_b,
    input  logic [N-1:0]   i_r,
    output logic [2*N-1:0] o_acc,
    output logic           o_mplier_lsb,
    output logic           o_next_mplier_zero
);

    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_ld) begin
            r_acc    <= {{N{1'b0}}, i_r};
            r_mcand  <= {{N{1'b0}}, i_b};
            r_mplier <= i_q;
        end else if (i_step) begin
            // Carry-out of the 2N-bit add is dropped; the result range cannot overflow.
            if (i_add) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_acc              = r_acc;
    assign o_mplier_lsb       = r_mplier[0];
    assign o_next_mplier_zero = ((r_mplier >> 1) == '0);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: P = Q*B + R over up to N iterations.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   async active-low reset
//   i_q       multiplier (N bits), sampled in LOAD
//   i_b       multiplicand (N bits), sampled in LOAD
//   i_r       addend (N bits), sampled in LOAD
//   i_btn     level start request, debounced
//   o_p       accumulator (2N bits), valid while o_done=1
//   o_busy    high in LOAD and CALC
//   o_done    high in DONE
// Macro MULT_EARLY_EXIT_EN: CALC also finishes once the remaining multiplier
// bits are all zero, giving data-dependent latency with identical results.
//
// state | meaning
// IDLE  | waiting for button, P holds last result
// LOAD  | capture operands, preset counter
// CALC  | one shift/add iteration per cycle
// DONE  | result valid, wait for button release
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_q,
    input  logic [N-1:0]   i_b,
    input  logic [N-1:0]   i_r,
    input  logic           i_btn,
    output logic [2*N-1:0] o_p,
    output logic           o_busy,
    output logic           o_done
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

`ifdef MULT_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;

    logic w_ld;
    logic w_step;
    logic w_add;
    logic w_mplier_lsb;
    logic w_next_zero;
    logic w_last;

    assign w_ld   = (r_state == ST_LOAD);
    assign w_step = (r_state == ST_CALC);
    assign w_add  = w_step & w_mplier_lsb;
    assign w_last = (r_cnt == '0) || (EARLY_EXIT && w_next_zero);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_btn) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= ST_CALC;
                end
                ST_CALC: begin
                    // Hold at zero on an early exit rather than wrapping.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!i_btn) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    shift_add_dp #(.N(N)) u_dp (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_ld               (w_ld),
        .i_step             (w_step),
        .i_add              (w_add),
        .i_q                (i_q),
        .i_b                (i_b),
        .i_r                (i_r),
        .o_acc              (o_p),
        .o_mplier_lsb       (w_mplier_lsb),
        .o_next_mplier_zero (w_next_zero)
    );

    assign o_busy = (r_state == ST_LOAD) || (r_state == ST_CALC);
    assign o_done = (r_state == ST_DONE);

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add multiplier that reconstructs a dividend from divider results: computes P = Q·B + R over N iterations. It is the inverse companion of the restoring divider and uses the same board conventions: operands on switches, start on a button, result on LEDs or display. It is also used as a round-trip checker on the divider's quotient and remainder. It has one FSM, one iteration counter, and a registered accumulator.

## Interface
- N, default 6, operand width. Q, B and R are each N bits; P is 2N bits.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- Q  in  N  multiplier, normally the divider's quotient.
- B  in  N  multiplicand, normally the divisor.
- R  in  N  addend, normally the divider's remainder.
- BTN  in  1  start request; level-sensitive; already debounced.
- P  out  2N  accumulator; holds Q·B + R when DONE=1.
- BUSY  out  1  high in LOAD and CALC.
- DONE  out  1  high in DONE state; result valid.

## Operation
- States: IDLE, LOAD, CALC, DONE.
- IDLE
  - BTN=1 → LOAD; otherwise stay.
  - P holds the previous result (0 after reset).
- LOAD, single cycle
  - acc ← zero-extended R.
  - mcand (2N bits) ← zero-extended B.
  - mplier (N bits) ← Q.
  - cnt ← N−1.
  - → CALC.
- CALC, one iteration per cycle
  - If mplier[0]=1, acc ← acc + mcand (2N-bit add, carry-out discarded).
  - mcand ← mcand<<1; mplier ← mplier>>1; cnt ← cnt−1.
  - When cnt=0 at this edge → DONE.
- DONE
  - DONE=1, P stable.
  - Stays while BTN=1; BTN=0 → IDLE.
  - A held button never retriggers.
- Width rule: the maximum (2^N−1)² + (2^N−1) = 2^2N − 2^N fits in 2N bits, so no overflow is possible.
- Q, B and R are sampled only at the LOAD edge; later changes are ignored until the next start.
- BTN is ignored in LOAD and CALC.
- P is driven directly from acc; it updates during CALC and is meaningful only while DONE=1.
- RST_N low at any time, including mid-CALC:
  - state → IDLE.
  - acc, mcand, mplier, cnt → 0.
  - P=0, BUSY=0, DONE=0.
  - No pending start survives reset.

## Timing
- Reset values: P=0, BUSY=0, DONE=0, state IDLE.
- Edge 0: BTN=1 sampled in IDLE → LOAD; BUSY=1 after edge 0.
- Edge 1: operands loaded → CALC.
- Edges 2 … N+1: N iterations. DONE=1 and BUSY=0 after edge N+1.
- Latency from start sample to DONE is N+2 cycles (8 for N=6), fixed unless MULT_EARLY_EXIT_EN is defined.
- DONE deasserts one edge after BTN is sampled low in DONE.

## Configuration
- MULT_EARLY_EXIT_EN defined
  - CALC also exits to DONE on the edge where the next mplier value (mplier>>1) is 0, including the iteration in which mplier is already 0.
  - Latency is 2 + max(1, index of Q's highest set bit + 1) cycles.
  - The result is identical to the fixed-latency mode.
- Not defined: CALC always runs exactly N iterations and latency is a constant N+2.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, LOAD, CALC, DONE);
  - the default width constant MULT_N = 6;
  - the counter width, clog2(N).
- One natural sub-module, shift_add_dp: holds acc, mcand, mplier and the conditional adder.
  - Controls in: ld, step.
  - Status out: mplier_lsb, next_mplier_zero.
- The FSM and counter stay in the top module.

## Test plan
- Reset, then Q=5, B=7, R=3, BTN pulse held 1 cycle → DONE after 8 cycles, P=38, BUSY high for exactly 7 cycles.
- Q=63, B=63, R=63 → P=4032 (0xFC0), no wrap; with the macro, latency is still 8.
- Q=0, B=45, R=12 → P=12. Without the macro DONE comes at cycle 8; with MULT_EARLY_EXIT_EN, DONE comes at cycle 3.
- BTN held high through completion → a single computation; DONE stays 1 until BTN drops, then IDLE. A new press with Q=2, B=3, R=1 gives P=7.
- Operands changed and BTN toggled during CALC → result still matches operands sampled at LOAD; no restart.
- RST_N asserted mid-CALC (cycle 4) → P, BUSY and DONE are 0 immediately (asynchronously). After release, a fresh start with Q=10, B=6, R=4 gives P=64.
